write_access_arbiter: RTL and testbench
=======================================

Name: write_access_arbiter

Overview:
- Arbitrates four requesters (module IDs 0-3) onto one shared memory write port.
- Checks every granted write against a programmable per-module address window before committing it.
- Blocks and reports violating writes through a held alert record.
- Locks out any module that reaches a violation threshold.
- Sits between the requesting modules and the protected memory, upstream of any alert/monitor logic.

Parameters:
ADDR_W, 4, write address width
DATA_W, 4, write data width
LOCK_THRESH, 3, violations per module before lockout (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  4  bit i = requester i has a write pending
req_addr  in  4*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
req_data  in  4*DATA_W  requester i data at [i*DATA_W +: DATA_W]
req_ready  out  4  one-hot grant; transfer on req_valid[i] & req_ready[i]
cfg_we  in  1  table write strobe
cfg_id  in  2  table entry index
cfg_lo  in  ADDR_W  window low bound, inclusive
cfg_hi  in  ADDR_W  window high bound, inclusive
cfg_en  in  1  entry enable
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_data  out  DATA_W  memory data
alert_valid  out  1  violation record held
alert_id  out  2  violating module
alert_addr  out  ADDR_W  violating address
alert_data  out  DATA_W  violating data
alert_overflow  out  1  violation dropped while record held
alert_ack  in  1  clears alert record
locked  out  4  bit i = module i locked out

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); it is sampled on the clk rising edge only.
- Reset:
  - FSM=IDLE; all outputs 0.
  - RR pointer=3, so ID 0 has first priority.
  - Violation counters = 0.
  - Table defaults: id1 = [0xA,0xA] enabled; id2 = [0xC,0xC] enabled; id0 and id3 disabled, lo=hi=0.
  - Reset mid-transaction drops the in-flight write; no mem_we, no alert.
- FSM states IDLE -> CHECK -> COMMIT -> IDLE. Throughput is one write per 3 cycles.
- IDLE:
  - Eligible set = req_valid & ~locked.
  - If non-empty, req_ready is driven combinationally, one-hot, to the first eligible ID after the RR pointer, wrapping 3->0.
  - At the edge: latch id/addr/data, set RR pointer to the winner, go to CHECK.
  - If the eligible set is empty, req_ready=0 and the FSM stays in IDLE.
  - req_ready is 0 in CHECK and COMMIT.
- CHECK:
  - auth = en[id] && lo[id] <= addr <= hi[id], unsigned compare.
  - lo > hi never matches.
  - Registered result, then go to COMMIT.
  - Uses table contents as of the start of the cycle; a same-cycle cfg write is not seen.
- COMMIT:
  - auth=1: mem_we=1 for exactly this cycle, with mem_addr/mem_data = latched values. mem_addr/mem_data are 0 otherwise.
  - auth=0: mem_we stays 0, and the violation counter[id] increments, saturating at LOCK_THRESH.
  - When a counter reaches LOCK_THRESH, locked[id]=1 from the next cycle.
- Alert capture (on the CHECK->COMMIT edge when auth=0):
  - alert_valid=0: load id/addr/data and set alert_valid. The record is visible in the COMMIT cycle, 2 cycles after grant.
  - alert_valid=1 and no ack in the same cycle: record unchanged, alert_overflow set (sticky).
  - alert_ack and a new violation in the same cycle: the new record is captured, alert_valid stays 1, alert_overflow clears.
  - alert_ack alone: alert_valid and alert_overflow cleared next cycle; alert fields return to 0.
- Config:
  - cfg_we writes entry cfg_id (lo, hi, en) at the edge, in any state.
  - The same write clears counter[cfg_id] and locked[cfg_id].
  - Lock is otherwise cleared only by rst.
- Widths: counters are 3 bits; no arithmetic wrap.

Test Plan:
- After reset, only req1 valid with addr=0xA, data=0x5: req_ready=0010 in cycle 0; mem_we=1, mem_addr=0xA, mem_data=0x5 in cycle 2; alert_valid stays 0.
- All four requesters held valid with authorized writes: grants in order 0,1,2,3,0, each 3 cycles apart.
- req0 write at addr 0x3 (id0 disabled): no mem_we; alert_valid=1, alert_id=0, alert_addr=0x3 in cycle 2. A second violation before ack sets alert_overflow=1 with the record unchanged.
- req3 makes three violations: locked=1000 after the third. req3 then gets no further req_ready while req_valid[3]=1. cfg_we id3 [0x0,0xF] enabled clears the lock, and the next req3 write commits.
- alert_ack in the same cycle as a new violation from id2 at addr 0x7: alert_valid stays 1, alert_id=2, alert_addr=0x7, alert_overflow=0.
- rst asserted during CHECK of an authorized write: no mem_we follows; all outputs 0; table back to defaults.

Source files
------------

// File: rtl/write_access_arbiter.sv
// Round-robin write arbiter for four requesters with per-module address windows,
// violation alert record and threshold lockout. One write per IDLE->CHECK->COMMIT pass.
module write_access_arbiter #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req_valid,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_id,
  input  logic [ADDR_W-1:0]     cfg_lo,
  input  logic [ADDR_W-1:0]     cfg_hi,
  input  logic                  cfg_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic                  alert_valid,
  output logic [1:0]            alert_id,
  output logic [ADDR_W-1:0]     alert_addr,
  output logic [DATA_W-1:0]     alert_data,
  output logic                  alert_overflow,
  input  logic                  alert_ack,
  output logic [3:0]            locked
);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  localparam logic [2:0] THR = 3'(LOCK_THRESH);

  state_t              state_q;
  logic [1:0]          rr_q;
  logic [1:0]          id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                auth_q;
  logic [2:0]          cnt_q [4];
  logic [3:0]          locked_q;
  logic [ADDR_W-1:0]   lo_q [4];
  logic [ADDR_W-1:0]   hi_q [4];
  logic [3:0]          en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic                alert_valid_q;
  logic [1:0]          alert_id_q;
  logic [ADDR_W-1:0]   alert_addr_q;
  logic [DATA_W-1:0]   alert_data_q;
  logic                alert_ovf_q;

  logic [3:0]          grant;
  logic [1:0]          win;
  logic                found;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                in_win;
  logic                viol;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant = '0;
    win   = rr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = rr_q + k[1:0];
      if (!found && req_valid[idx] && !locked_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (state_q == IDLE && found) grant[win] = 1'b1;
    sel_addr = req_addr[win*ADDR_W +: ADDR_W];
    sel_data = req_data[win*DATA_W +: DATA_W];
  end

  assign in_win = en_q[id_q] && (lo_q[id_q] <= addr_q) && (addr_q <= hi_q[id_q]);
  assign viol   = (state_q == CHECK) && !in_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_q          <= 2'd3;
      id_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      auth_q        <= 1'b0;
      locked_q      <= '0;
      en_q          <= 4'b0110;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      alert_valid_q <= 1'b0;
      alert_id_q    <= '0;
      alert_addr_q  <= '0;
      alert_data_q  <= '0;
      alert_ovf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        lo_q[i]  <= '0;
        hi_q[i]  <= '0;
      end
      lo_q[1] <= ADDR_W'('hA);
      hi_q[1] <= ADDR_W'('hA);
      lo_q[2] <= ADDR_W'('hC);
      hi_q[2] <= ADDR_W'('hC);
    end else begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;

      case (state_q)
        IDLE: begin
          if (found) begin
            id_q    <= win;
            addr_q  <= sel_addr;
            data_q  <= sel_data;
            rr_q    <= win;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          auth_q  <= in_win;
          state_q <= COMMIT;
          if (in_win) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= data_q;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (!auth_q && cnt_q[id_q] < THR) begin
            cnt_q[id_q] <= cnt_q[id_q] + 3'd1;
            if (cnt_q[id_q] + 3'd1 == THR) locked_q[id_q] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // An ack in the same cycle as a new violation frees the slot for it.
      if (viol && (!alert_valid_q || alert_ack)) begin
        alert_valid_q <= 1'b1;
        alert_id_q    <= id_q;
        alert_addr_q  <= addr_q;
        alert_data_q  <= data_q;
        alert_ovf_q   <= 1'b0;
      end else if (viol) begin
        alert_ovf_q <= 1'b1;
      end else if (alert_ack) begin
        alert_valid_q <= 1'b0;
        alert_id_q    <= '0;
        alert_addr_q  <= '0;
        alert_data_q  <= '0;
        alert_ovf_q   <= 1'b0;
      end

      // Reprogramming an entry also forgives that module's history.
      if (cfg_we) begin
        lo_q[cfg_id]     <= cfg_lo;
        hi_q[cfg_id]     <= cfg_hi;
        en_q[cfg_id]     <= cfg_en;
        cnt_q[cfg_id]    <= '0;
        locked_q[cfg_id] <= 1'b0;
      end
    end
  end

  assign req_ready      = grant;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data       = mem_data_q;
  assign alert_valid    = alert_valid_q;
  assign alert_id       = alert_id_q;
  assign alert_addr     = alert_addr_q;
  assign alert_data     = alert_data_q;
  assign alert_overflow = alert_ovf_q;
  assign locked         = locked_q;

endmodule

// File: tb/tb_write_access_arbiter.sv
// Cycle-vector bench for write_access_arbiter: inputs driven on the falling edge,
// outputs compared shortly after, before the next rising edge.
module tb_write_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [1:0]  cfg_id;
  logic [3:0]  cfg_lo, cfg_hi;
  logic        cfg_en;
  logic        mem_we;
  logic [3:0]  mem_addr, mem_data;
  logic        alert_valid;
  logic [1:0]  alert_id;
  logic [3:0]  alert_addr, alert_data;
  logic        alert_overflow;
  logic        alert_ack;
  logic [3:0]  locked;

  always #5 clk = ~clk;

  write_access_arbiter #(.ADDR_W(4), .DATA_W(4), .LOCK_THRESH(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_en(cfg_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .alert_valid(alert_valid), .alert_id(alert_id), .alert_addr(alert_addr),
    .alert_data(alert_data), .alert_overflow(alert_overflow), .alert_ack(alert_ack),
    .locked(locked)
  );

  typedef struct packed {
    logic [3:0] rdy;
    logic       we;
    logic [3:0] maddr;
    logic [3:0] mdata;
    logic       av;
    logic [1:0] aid;
    logic [3:0] aaddr;
    logic [3:0] adata;
    logic       aovf;
    logic [3:0] lck;
  } out_t;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [15:0] ra;
    logic [15:0] rd;
    logic        ack;
    logic [11:0] cfg;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  localparam out_t Z = '0;

  function automatic out_t o(input logic [3:0] rdy, input logic we, input logic [3:0] maddr,
                             input logic [3:0] mdata, input logic av, input logic [1:0] aid,
                             input logic [3:0] aaddr, input logic [3:0] adata,
                             input logic aovf, input logic [3:0] lck);
    out_t r;
    r = '{rdy, we, maddr, mdata, av, aid, aaddr, adata, aovf, lck};
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] rv, input logic [15:0] ra, input logic [15:0] rd,
                              input out_t e, input logic ack = 1'b0, input logic r = 1'b0,
                              input logic [11:0] cfg = 12'h000);
    vec_t v;
    v.rst = r; v.rv = rv; v.ra = ra; v.rd = rd; v.ack = ack; v.cfg = cfg; v.exp = e;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string name);
    out_t got;
    @(negedge clk);
    rst       = v.rst;
    req_valid = v.rv;
    req_addr  = v.ra;
    req_data  = v.rd;
    alert_ack = v.ack;
    {cfg_we, cfg_id, cfg_lo, cfg_hi, cfg_en} = v.cfg;
    #2;
    got = '{req_ready, mem_we, mem_addr, mem_data, alert_valid, alert_id,
            alert_addr, alert_data, alert_overflow, locked};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b ma=%h md=%h av=%b aid=%0d aa=%h ad=%h ovf=%b lck=%b, want rdy=%b we=%b ma=%h md=%h av=%b aid=%0d aa=%h ad=%h ovf=%b lck=%b",
               name, got.rdy, got.we, got.maddr, got.mdata, got.av, got.aid, got.aaddr,
               got.adata, got.aovf, got.lck, v.exp.rdy, v.exp.we, v.exp.maddr, v.exp.mdata,
               v.exp.av, v.exp.aid, v.exp.aaddr, v.exp.adata, v.exp.aovf, v.exp.lck);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Authorized single write from id1 after reset.
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));
    add(mk(4'b0010, 16'h00A0, 16'h0050, o(4'b0010,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,1,4'hA,4'h5,0,0,0,0,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));
    // id0 disabled: violation, then a second one overflows the held record.
    add(mk(4'b0001, 16'h0003, 16'h0009, o(4'b0001,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,0,0,0,1,0,4'h3,4'h9,0,0)));
    add(mk(4'b0001, 16'h0004, 16'h0006, o(4'b0001,0,0,0,1,0,4'h3,4'h9,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,0,0,0,1,0,4'h3,4'h9,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,0,0,0,1,0,4'h3,4'h9,1,0)));
    // id2 at 0x7 violates while ack arrives on the same edge.
    add(mk(4'b0100, 16'h0700, 16'h0100, o(4'b0100,0,0,0,1,0,4'h3,4'h9,1,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,0,0,0,1,0,4'h3,4'h9,1,0), 1'b1));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,0,0,0,1,2,4'h7,4'h1,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,0,0,0,1,2,4'h7,4'h1,0,0), 1'b1));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));
    // id3 three violations -> lockout, then cfg write unlocks.
    for (int n = 0; n < 3; n++) begin
      add(mk(4'b1000, 16'h5000, 16'h2000, o(4'b1000,0,0,0,0,0,0,0,0,0)));
      add(mk(4'b1000, 16'h5000, 16'h2000, Z));
      add(mk(4'b1000, 16'h5000, 16'h2000, o(0,0,0,0,1,3,4'h5,4'h2,0,0), 1'b1));
    end
    add(mk(4'b1000, 16'h5000, 16'h2000, o(0,0,0,0,0,0,0,0,0,4'b1000)));
    add(mk(4'b1000, 16'h5000, 16'h2000, o(0,0,0,0,0,0,0,0,0,4'b1000)));
    add(mk(4'b1000, 16'h5000, 16'h2000, o(0,0,0,0,0,0,0,0,0,4'b1000), 1'b0, 1'b0,
           {1'b1, 2'd3, 4'h0, 4'hF, 1'b1}));
    add(mk(4'b1000, 16'h5000, 16'h2000, o(4'b1000,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b1000, 16'h5000, 16'h2000, Z));
    add(mk(4'b1000, 16'h5000, 16'h2000, o(0,1,4'h5,4'h2,0,0,0,0,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z, 1'b0, 1'b0, {1'b1, 2'd0, 4'h0, 4'hF, 1'b1}));
    // All four valid: round-robin 0,1,2,3,0, three cycles apart.
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(4'b0001,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, Z));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(0,1,4'h1,4'h1,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(4'b0010,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, Z));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(0,1,4'hA,4'h2,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(4'b0100,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, Z));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(0,1,4'hC,4'h3,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(4'b1000,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, Z));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(0,1,4'hE,4'h4,0,0,0,0,0,0)));
    add(mk(4'b1111, 16'hECA1, 16'h4321, o(4'b0001,0,0,0,0,0,0,0,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));
    add(mk(4'b0000, 16'h0000, 16'h0000, o(0,1,4'h1,4'h1,0,0,0,0,0,0)));
    add(mk(4'b0000, 16'h0000, 16'h0000, Z));

    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; alert_ack = 1'b0;
    cfg_we = 1'b0; cfg_id = '0; cfg_lo = '0; cfg_hi = '0; cfg_en = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset during CHECK drops the write and restores pointer and table defaults.
    apply(mk(4'b0010, 16'h00A0, 16'h0050, o(4'b0010,0,0,0,0,0,0,0,0,0)), "rst_grant");
    apply(mk(4'b0000, 16'h0000, 16'h0000, Z, 1'b0, 1'b1), "rst_in_check");
    apply(mk(4'b0000, 16'h0000, 16'h0000, Z), "rst_no_commit");
    apply(mk(4'b0101, 16'h0C01, 16'h0306, o(4'b0001,0,0,0,0,0,0,0,0,0)), "rst_rr_ptr");
    apply(mk(4'b0100, 16'h0C01, 16'h0306, Z), "rst_check2");
    apply(mk(4'b0100, 16'h0C01, 16'h0306, o(0,0,0,0,1,0,4'h1,4'h6,0,0), 1'b1), "rst_id0_default");
    apply(mk(4'b0100, 16'h0C01, 16'h0306, o(4'b0100,0,0,0,0,0,0,0,0,0)), "rst_grant2");
    apply(mk(4'b0000, 16'h0000, 16'h0000, Z), "rst_check3");
    apply(mk(4'b0000, 16'h0000, 16'h0000, o(0,1,4'hC,4'h3,0,0,0,0,0,0)), "rst_id2_default");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
